paint_dispense_seq: RTL
=======================

# paint_dispense_seq

Sequencer that turns one dispense request (step counts for red, yellow and blue) into enable and direction commands for the three `stepper_motor_driver` instances.
- Sits directly upstream of those drivers, replacing the raw switch decode.
- Runs the colours strictly one at a time (red, yellow, blue), skips zero amounts and inserts a settle gap between colours.
- Reports completion with a `busy`/`done` handshake.

## Interface
- `AMT_W`, 8, width of each per-colour step count.
- `GAP_TICKS`, 4, settle ticks between consecutive dispensed colours; 0 means no gap.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle strobe, one per motor step period, synchronous to `clk`.
- `start`  in  1  request strobe; sampled only in IDLE.
- `abort`  in  1  stop immediately and return to IDLE.
- `dir_in`  in  1  direction for this request; latched on accepted `start`.
- `amt_r`  in  AMT_W  red step count; latched on accepted `start`.
- `amt_y`  in  AMT_W  yellow step count; latched on accepted `start`.
- `amt_b`  in  AMT_W  blue step count; latched on accepted `start`.
- `en_red`  out  1  red motor enable.
- `en_yellow`  out  1  yellow motor enable.
- `en_blue`  out  1  blue motor enable.
- `dir`  out  1  latched direction to all drivers.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **State machine:** IDLE, RUN_R, RUN_Y, RUN_B, GAP, DONE.
- **Registered outputs:**
  - `en_red`/`en_yellow`/`en_blue` = 1 only in RUN_R/RUN_Y/RUN_B respectively; at most one enable high at any time.
  - `busy` = 1 in RUN_*, GAP.
  - `done` = 1 only in DONE.
  - `dir` holds its latched value until the next accepted `start`.
- **Reset:** state IDLE; all enables 0; `busy`=0; `done`=0; `dir`=0; counters and latched amounts 0.
- **IDLE:** `start`=1 accepts the request.
  - Latch the three amounts and `dir_in`.
  - Next state is RUN of the first colour with nonzero amount, loading step counter = that amount.
  - If all three amounts are 0, next state is DONE.
- **RUN_x:** each cycle with `tick`=1 decrements the step counter (AMT_W bits). On a tick with counter==1:
  - If a later colour has a nonzero amount: go to GAP with gap counter = GAP_TICKS, or, when GAP_TICKS==0, directly to RUN of that colour.
  - Otherwise go to DONE.
- **GAP:** each `tick` decrements the gap counter. On a tick with counter==1, go to RUN of the next nonzero colour and load its amount.
- **DONE:** lasts exactly one cycle, then IDLE.
- **Input rules:**
  - `start` outside IDLE is ignored.
  - Amount inputs are ignored after latching.
- **`abort`:**
  - Takes priority over every other input, including `start` in the same cycle.
  - From any state: next state IDLE, enables 0, `busy`=0, `done` not pulsed.
- **`rst`:** takes priority over `abort`. Reset mid-run behaves as abort plus clearing `dir`.

## Timing
- **Start latency:** `start` accepted in cycle 0 → first enable and `busy` high in cycle 1.
- **Steps per colour:** a colour with amount N keeps its enable high across exactly N `tick` strobes. The enable drops in the cycle after the Nth tick.
- **Back-to-back colours (GAP_TICKS==0):** the next colour's enable rises in the same cycle the previous one falls; no overlap and no idle cycle.
- **With gap:** all enables are low for exactly GAP_TICKS tick strobes between colours.
- **Completion:**
  - `done`=1 and `busy`=0 in the cycle after the last tick of the last dispensed colour.
  - All-zero request: `done` in cycle 1.
  - The earliest next `start` is accepted in the cycle after `done`.
- **Tick vs. transition:** a `tick` in the same cycle as a state transition is counted only by the state being left; ticks in IDLE/DONE are ignored.
- **Counter sizes:** amount 2^AMT_W−1 is the maximum; no wrap occurs because a counter never decrements below 1 in RUN or GAP.

## Test plan
- **Full request, tick every 4 cycles:** reset, then `start` with r=3, y=2, b=1, `dir_in`=1, GAP_TICKS=4.
  - `en_red` high for 3 ticks, 4-tick gap, `en_yellow` for 2 ticks, 4-tick gap, `en_blue` for 1 tick.
  - `done` pulses one cycle after the last tick; `dir`=1 throughout; enables never overlap.
- **Zero amounts:** r=0, y=5, b=0 → only `en_yellow` high, 5 ticks, no gap, then `done`. All zero → `done` at cycle 1, no enable.
- **Abort mid-run:** `abort` during the 2nd yellow tick → next cycle all enables 0, `busy`=0, no `done`. A new `start` the following cycle is accepted.
- **Start while busy:** `start` pulses while `busy`=1 are ignored; latched amounts stay unchanged, verified by step counts matching the original request.
- **Simultaneous events:**
  - `start`+`abort` in IDLE → stays IDLE.
  - `rst` asserted mid-GAP → all outputs reach their reset values next cycle.
- **Boundary amount:** GAP_TICKS=0, r=255, y=1, b=0 → `en_red` for 255 ticks, `en_yellow` rises the cycle `en_red` falls, 1 tick, then `done`.

Source files
------------

// File: rtl/paint_dispense_seq.sv
// rtl/paint_dispense_seq.sv - one-colour-at-a-time dispense sequencer driving the red/yellow/blue stepper enables
module paint_dispense_seq #(
    parameter int AMT_W     = 8,
    parameter int GAP_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic             dir_in,
    input  logic [AMT_W-1:0] amt_r,
    input  logic [AMT_W-1:0] amt_y,
    input  logic [AMT_W-1:0] amt_b,
    output logic             en_red,
    output logic             en_yellow,
    output logic             en_blue,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [AMT_W-1:0] STEP_ONE = AMT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN_R = 3'd1,
        S_RUN_Y = 3'd2,
        S_RUN_B = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] amt_r_q, amt_r_d;
    logic [AMT_W-1:0] amt_y_q, amt_y_d;
    logic [AMT_W-1:0] amt_b_q, amt_b_d;
    logic [AMT_W-1:0] step_q, step_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       nxt_q, nxt_d;
    logic             dir_q, dir_d;
    logic             en_red_q, en_red_d;
    logic             en_yellow_q, en_yellow_d;
    logic             en_blue_q, en_blue_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Colour codes: 0 red, 1 yellow, 2 blue.
    logic             has_later;
    logic [1:0]       later_col;
    logic [1:0]       tgt_col;
    state_t           tgt_state;
    logic [AMT_W-1:0] tgt_amt;

    // Next nonzero colour after the one currently running, and the run
    // state/amount of whichever colour is about to be entered.
    always_comb begin
        has_later = 1'b0;
        later_col = 2'd0;
        case (state_q)
            S_RUN_R: begin
                if (amt_y_q != '0) begin
                    has_later = 1'b1;
                    later_col = 2'd1;
                end else if (amt_b_q != '0) begin
                    has_later = 1'b1;
                    later_col = 2'd2;
                end
            end
            S_RUN_Y: begin
                if (amt_b_q != '0) begin
                    has_later = 1'b1;
                    later_col = 2'd2;
                end
            end
            default: ;
        endcase

        tgt_col   = (state_q == S_GAP) ? nxt_q : later_col;
        tgt_state = S_RUN_R;
        tgt_amt   = amt_r_q;
        case (tgt_col)
            2'd1: begin
                tgt_state = S_RUN_Y;
                tgt_amt   = amt_y_q;
            end
            2'd2: begin
                tgt_state = S_RUN_B;
                tgt_amt   = amt_b_q;
            end
            default: begin
                tgt_state = S_RUN_R;
                tgt_amt   = amt_r_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        amt_r_d = amt_r_q;
        amt_y_d = amt_y_q;
        amt_b_d = amt_b_q;
        step_d  = step_q;
        gap_d   = gap_q;
        nxt_d   = nxt_q;
        dir_d   = dir_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    amt_r_d = amt_r;
                    amt_y_d = amt_y;
                    amt_b_d = amt_b;
                    dir_d   = dir_in;
                    if (amt_r != '0) begin
                        state_d = S_RUN_R;
                        step_d  = amt_r;
                    end else if (amt_y != '0) begin
                        state_d = S_RUN_Y;
                        step_d  = amt_y;
                    end else if (amt_b != '0) begin
                        state_d = S_RUN_B;
                        step_d  = amt_b;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN_R, S_RUN_Y, S_RUN_B: begin
                if (tick) begin
                    // Stop at 1 rather than 0 so the counter never wraps.
                    if (step_q == STEP_ONE) begin
                        if (!has_later) begin
                            state_d = S_DONE;
                        end else if (GAP_TICKS == 0) begin
                            state_d = tgt_state;
                            step_d  = tgt_amt;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                            nxt_d   = later_col;
                        end
                    end else begin
                        step_d = step_q - STEP_ONE;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_ONE) begin
                        state_d = tgt_state;
                        step_d  = tgt_amt;
                    end else begin
                        gap_d = gap_q - GAP_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats a same-cycle start: nothing gets latched.
        if (abort) begin
            state_d = S_IDLE;
            amt_r_d = amt_r_q;
            amt_y_d = amt_y_q;
            amt_b_d = amt_b_q;
            dir_d   = dir_q;
        end

        en_red_d    = (state_d == S_RUN_R);
        en_yellow_d = (state_d == S_RUN_Y);
        en_blue_d   = (state_d == S_RUN_B);
        busy_d      = (state_d == S_RUN_R) || (state_d == S_RUN_Y) ||
                      (state_d == S_RUN_B) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            amt_r_q     <= '0;
            amt_y_q     <= '0;
            amt_b_q     <= '0;
            step_q      <= '0;
            gap_q       <= '0;
            nxt_q       <= 2'd0;
            dir_q       <= 1'b0;
            en_red_q    <= 1'b0;
            en_yellow_q <= 1'b0;
            en_blue_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            amt_r_q     <= amt_r_d;
            amt_y_q     <= amt_y_d;
            amt_b_q     <= amt_b_d;
            step_q      <= step_d;
            gap_q       <= gap_d;
            nxt_q       <= nxt_d;
            dir_q       <= dir_d;
            en_red_q    <= en_red_d;
            en_yellow_q <= en_yellow_d;
            en_blue_q   <= en_blue_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign en_red    = en_red_q;
    assign en_yellow = en_yellow_q;
    assign en_blue   = en_blue_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
